// File: rtl/scoreboard_pkg.sv
// Shared constants, display payload type and per-digit helpers for the scoreboard core.
package scoreboard_pkg;

  localparam int unsigned MODE_HEX = 0;
  localparam int unsigned MODE_BCD = 1;
  localparam int unsigned DIG_W    = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One 7-segment frame, active low, laid out as {dp,g,f,e,d,c,b,a}
  typedef struct packed {
    logic       dp;
    logic [6:0] gfedcba;
  } seg_t;

  function automatic logic [6:0] seg_glyph(input logic [DIG_W-1:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Increment/decrement one digit with wrap at F (hex) or 9 (BCD)
  function automatic logic [DIG_W-1:0] digit_step(input logic [DIG_W-1:0] d,
                                                  input logic dn, input logic bcd);
    logic [DIG_W-1:0] top;
    logic [DIG_W-1:0] r;
    top = bcd ? 4'd9 : 4'hF;
    if (dn) r = (d == 4'd0) ? top : d - 4'd1;
    else    r = (d >= top) ? 4'd0 : d + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/score_board_ctrl_btn_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level and press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_c
);

  localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;
  logic             s;

  assign s       = sync_q[1];
  assign press_c = stable & ~stable_q;

  // Any cycle where the synchronised level matches the accepted level restarts qualification
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      stable_q <= stable;
      if (s != stable) begin
        if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          stable <= s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/score_board_ctrl.sv
// Scoreboard core: debounced per-digit up/down counters plus a multiplexed 7-segment scanner.
module score_board_ctrl
  import scoreboard_pkg::*;
#(
  parameter int unsigned N_DIG     = 4,
  parameter int unsigned DB_CYCLES = 2000000,
  parameter int unsigned SCAN_DIV  = 17,
  parameter int unsigned MODE      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_DIG-1:0]       btn,
  input  logic                   dec,
  input  logic                   clr,
  input  logic [N_DIG-1:0]       points,
  input  logic [N_DIG-1:0]       le,
  output logic [4*N_DIG-1:0]     num,
  output logic [N_DIG-1:0]       AN,
  output logic [7:0]             SEGMENT
);

  localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic        BCD   = (MODE == MODE_BCD);

  logic [N_DIG-1:0]            press_c;
  logic [N_DIG-1:0][DIG_W-1:0] dig;
  logic [SCAN_DIV-1:0]         pre;
  logic [IDX_W-1:0]            idx;
  seg_t                        seg_nxt_c;

  assign num = dig;

  for (genvar i = 0; i < N_DIG; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn[i]),
      .press_c (press_c[i])
    );
  end

  // Clear wins over any coincident press; digits are independent, no carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig <= '0;
    end else if (clr) begin
      dig <= '0;
    end else begin
      for (int i = 0; i < N_DIG; i++) begin
        if (press_c[i]) dig[i] <= digit_step(dig[i], dec, BCD);
      end
    end
  end

  // Free-running prescaler; scan index advances on each wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + SCAN_DIV'(1);
      if (&pre) idx <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  always_comb begin
    seg_nxt_c.dp      = ~points[idx];
    seg_nxt_c.gfedcba = seg_glyph(dig[idx]);
    if (le[idx]) begin
      seg_nxt_c.dp      = 1'b1;
      seg_nxt_c.gfedcba = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN      <= '1;
      SEGMENT <= 8'hFF;
    end else begin
      AN      <= ~(N_DIG'(1) << idx);
      SEGMENT <= seg_nxt_c;
    end
  end

endmodule

// File: doc/score_board_ctrl.md
Name: score_board_ctrl

Overview:
- Parametrised scoreboard core: N_DIG push-buttons, each debounced, each owning one 4-bit score digit.
- A clean press increments the digit, or decrements it when dec=1. Digits wrap in hex or BCD mode.
- Built-in time-multiplexed 7-segment scanner drives AN/SEGMENT directly, with per-digit decimal point and blanking.
- Sits under the board top level, between raw buttons/switches and the display pins; replaces the separate number-generator plus display-driver pair.

Parameters:
- N_DIG, 4, number of channels = digits = buttons (1..8).
- DB_CYCLES, 2000000, consecutive stable cycles required to accept a button level change (>=2).
- SCAN_DIV, 17, prescaler width; the digit index advances each time the SCAN_DIV-bit prescaler wraps.
- MODE, 0, 0 = hex digits (0..F), 1 = BCD digits (0..9).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- btn  in  N_DIG  raw, asynchronous, bouncing buttons; bit i drives digit i.
- dec  in  1  0 = press increments, 1 = press decrements.
- clr  in  1  synchronous clear of all digits.
- points  in  N_DIG  1 = light the decimal point of digit i.
- le  in  N_DIG  1 = blank digit i.
- num  out  4*N_DIG  score, digit i at num[4i+3:4i].
- AN  out  N_DIG  digit enables, active low, one-hot.
- SEGMENT  out  8  {dp,g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - num = 0, debounced levels = 0, debounce counters = 0, press history = 0.
  - prescaler = 0, scan index = 0.
  - AN = all ones, SEGMENT = 8'hFF.
- Synchroniser: each btn bit goes through a 2-FF synchroniser, giving s[i].
- Debounce, per channel:
  - If s != stable, the counter increments.
  - When counter == DB_CYCLES-1 and s != stable: stable <= s, counter <= 0.
  - Any cycle with s == stable clears the counter, so a bounce restarts qualification.
- Press detection: press[i] = stable[i] & ~stable_q[i], a one-cycle pulse. Release produces no event.
- Latency: a raw edge held steady at cycle t makes stable change visible at t+2+DB_CYCLES; num changes at t+3+DB_CYCLES.
- Digit update on press[i]:
  - dec=0: d+1; hex wraps F->0, BCD wraps 9->0.
  - dec=1: d-1; hex wraps 0->F, BCD wraps 0->9.
  - Width is 4 bits, with no carry between digits.
  - dec is sampled in the same cycle as the press.
- Simultaneous events:
  - Presses on several channels in one cycle all apply independently.
  - clr=1 has priority: every digit goes to 0 that cycle and any coincident press is discarded.
  - clr does not affect the debounce state.
- Scan:
  - The prescaler counts freely.
  - On prescaler wrap (all ones -> 0), index <= (index == N_DIG-1) ? 0 : index+1.
- Display outputs, registered with 1-cycle latency from the index/num/points/le values:
  - AN = ~(1 << index).
  - SEGMENT[6:0] = active-low hex glyph of digit[index], or 7'h7F if le[index].
  - SEGMENT[7] = ~points[index], forced 1 if le[index].
- Glyphs (gfedcba, active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Reset asserted mid-qualification or mid-scan aborts everything to reset values. A button still held at release of reset is re-qualified and produces one press.

Decomposition:
- Shared package scoreboard_pkg:
  - MODE_HEX/MODE_BCD constants.
  - 16-entry 7-segment glyph table/function.
  - Blank constant 7'h7F.
- One sub-module, btn_debounce: synchroniser + counter + stable level + press pulse, parameter DB_CYCLES. Instantiated N_DIG times via generate.

Test Plan (N_DIG=4, DB_CYCLES=4, SCAN_DIV=3 unless noted):
- Reset: rst pulse -> num=16'h0000, AN=4'hF, SEGMENT=8'hFF; after the first scan update AN=4'hE, SEGMENT=8'hC0.
- Clean press: btn[0] high from cycle t -> num[3:0]=1 exactly at t+7; holding 20 more cycles gives no further change; release then re-press -> 2.
- Bounce: btn[1] toggles every 2 cycles for 12 cycles, then stays high -> exactly one increment, 7 cycles after the last edge.
- Wrap:
  - MODE=0: 16 presses on btn[2] from 0 -> F then 0.
  - MODE=1: 10 presses -> 9 then 0.
  - dec=1 press at 0 -> F (hex) or 9 (BCD).
- Simultaneous: btn[0], btn[3] qualify in the same cycle with clr=0 -> num=16'h1001. Repeat with clr=1 in the press cycle -> num=16'h0000.
- Scan/blank: num=16'h4321, points=4'b0010, le=4'b1000 -> cycle through AN E,D,B,7 with SEGMENT F9,24 (dp low),B0,FF, each held 8 cycles, then repeat.
